// File: rtl/rf_wport_arbiter_pkg.sv
// Shared widths, requester count and slot type for the register-file write-port arbiter.
package rf_wport_arbiter_pkg;

    localparam int NUM_REQ  = 3;
    localparam int D_WIDTH  = 32;
    localparam int RA_WIDTH = 5;

    localparam logic [1:0] GRANT_NONE = 2'd3;

    typedef struct packed {
        logic                full;
        logic [RA_WIDTH-1:0] addr;
        logic [D_WIDTH-1:0]  data;
    } slot_t;

    // Advance a requester index round-robin over 0..2
    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i >= 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

endpackage

// File: rtl/rf_wport_arbiter_rr_arbiter3.sv
// Combinational 3-way round-robin picker; the search starts just after last_grant.
module rr_arbiter3
    import rf_wport_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last_grant,
    output logic [2:0] grant,
    output logic [1:0] grant_idx,
    output logic       any_grant
);

    logic [1:0] idx;

    always_comb begin
        grant     = 3'b000;
        grant_idx = GRANT_NONE;
        any_grant = 1'b0;
        idx       = next_idx(last_grant);
        for (int k = 0; k < 3; k++) begin
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any_grant  = 1'b1;
            end
            idx = next_idx(idx);
        end
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: three 1-entry holding slots drained one per cycle
// in round-robin order onto a registered write port.
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
(
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*RA_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*D_WIDTH-1:0]    req_data,
    output logic                          W_en,
    output logic [RA_WIDTH-1:0]           W_Addr,
    output logic [D_WIDTH-1:0]            W_Data,
    output logic [1:0]                    grant_id,
    output logic                          busy
);

    slot_t      slot [NUM_REQ];
    logic [2:0] full_mask;
    logic [1:0] last_grant;
    logic [2:0] gnt_oh;
    logic [1:0] gnt_idx;
    logic       any_gnt;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) full_mask[i] = slot[i].full;
    end

    rr_arbiter3 u_rr (
        .req        (full_mask),
        .last_grant (last_grant),
        .grant      (gnt_oh),
        .grant_idx  (gnt_idx),
        .any_grant  (any_gnt)
    );

    // A slot being drained this cycle can accept a new entry on the same edge
    assign req_ready = ~full_mask | gnt_oh;
    assign busy      = |full_mask;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                slot[i].full <= 1'b0;
                slot[i].addr <= '0;
                slot[i].data <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    slot[i].full <= 1'b1;
                    slot[i].addr <= req_addr[i*RA_WIDTH +: RA_WIDTH];
                    slot[i].data <= req_data[i*D_WIDTH +: D_WIDTH];
                end else if (gnt_oh[i]) begin
                    slot[i].full <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            last_grant <= 2'd2;
            W_en       <= 1'b0;
            W_Addr     <= '0;
            W_Data     <= '0;
            grant_id   <= GRANT_NONE;
        end else if (any_gnt) begin
            last_grant <= gnt_idx;
            // r0 is hardwired: the grant is consumed but nothing is written
            W_en       <= (slot[gnt_idx].addr != '0);
            W_Addr     <= slot[gnt_idx].addr;
            W_Data     <= slot[gnt_idx].data;
            grant_id   <= gnt_idx;
        end else begin
            W_en       <= 1'b0;
            grant_id   <= GRANT_NONE;
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed self-checking bench for rf_wport_arbiter.
module tb_rf_wport_arbiter;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        W_en;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;
    logic [1:0]  grant_id;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    rf_wport_arbiter dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .W_en      (W_en),
        .W_Addr    (W_Addr),
        .W_Data    (W_Data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
        req_valid[i]        = v;
        req_addr[i*5 +: 5]  = a;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        tick();
        tick();
        Rst = 1'b0;
        #1;
    endtask

    initial begin
        Rst       = 1'b1;
        req_valid = 3'b000;
        req_addr  = '0;
        req_data  = '0;

        // Requests presented during reset must be discarded
        set_req(0, 1'b1, 5'd7, 32'hDEAD);
        set_req(1, 1'b1, 5'd8, 32'hBEEF);
        do_reset();
        req_valid = 3'b000;
        #1;
        chk("rst_wen",   {31'd0, W_en}, 32'd0);
        chk("rst_waddr", {27'd0, W_Addr}, 32'd0);
        chk("rst_wdata", W_Data, 32'd0);
        chk("rst_gid",   {30'd0, grant_id}, 32'd3);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_ready", {29'd0, req_ready}, 32'd7);
        tick();
        chk("rst_noleak_wen", {31'd0, W_en}, 32'd0);

        // Single ALU write r5 = 0x1234
        set_req(0, 1'b1, 5'd5, 32'h1234);
        tick();
        req_valid = 3'b000;
        #1;
        chk("single_busy", {31'd0, busy}, 32'd1);
        chk("single_wen_early", {31'd0, W_en}, 32'd0);
        tick();
        chk("single_wen",   {31'd0, W_en}, 32'd1);
        chk("single_waddr", {27'd0, W_Addr}, 32'd5);
        chk("single_wdata", W_Data, 32'h1234);
        chk("single_gid",   {30'd0, grant_id}, 32'd0);
        tick();
        chk("single_wen_off",  {31'd0, W_en}, 32'd0);
        chk("single_gid_none", {30'd0, grant_id}, 32'd3);
        chk("single_hold_addr", {27'd0, W_Addr}, 32'd5);
        chk("single_hold_data", W_Data, 32'h1234);
        chk("single_busy_off", {31'd0, busy}, 32'd0);

        // Contention: three requests in one cycle after reset
        do_reset();
        set_req(0, 1'b1, 5'd1, 32'h11);
        set_req(1, 1'b1, 5'd2, 32'h22);
        set_req(2, 1'b1, 5'd3, 32'h33);
        tick();
        req_valid = 3'b000;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("cont_wen",   {31'd0, W_en}, 32'd1);
            chk("cont_gid",   {30'd0, grant_id}, k);
            chk("cont_waddr", {27'd0, W_Addr}, k + 1);
            chk("cont_wdata", W_Data, 32'h11 * (k + 1));
        end
        tick();
        chk("cont_done_wen", {31'd0, W_en}, 32'd0);

        // Back-to-back LOAD transfers
        for (int k = 0; k < 4; k++) begin
            set_req(1, 1'b1, 5'd10, 32'd100 + k);
            #1;
            chk("b2b_ready", {31'd0, req_ready[1]}, 32'd1);
            tick();
            if (k > 0) begin
                chk("b2b_wen",   {31'd0, W_en}, 32'd1);
                chk("b2b_wdata", W_Data, 32'd100 + k - 1);
                chk("b2b_gid",   {30'd0, grant_id}, 32'd1);
            end
        end
        req_valid = 3'b000;
        tick();
        chk("b2b_last_wen",   {31'd0, W_en}, 32'd1);
        chk("b2b_last_wdata", W_Data, 32'd103);
        tick();
        chk("b2b_end_wen", {31'd0, W_en}, 32'd0);

        // MULDIV write to r0 is consumed without a write
        set_req(2, 1'b1, 5'd0, 32'hFFFF);
        tick();
        req_valid = 3'b000;
        #1;
        chk("zero_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("zero_gid",   {30'd0, grant_id}, 32'd2);
        chk("zero_wen",   {31'd0, W_en}, 32'd0);
        chk("zero_busy_off", {31'd0, busy}, 32'd0);
        chk("zero_ready", {29'd0, req_ready}, 32'd7);

        // Fairness: ALU and LOAD both continuously valid
        do_reset();
        set_req(0, 1'b1, 5'd4, 32'hA0);
        set_req(1, 1'b1, 5'd6, 32'hB0);
        tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("fair_gid", {30'd0, grant_id}, (k % 2 == 0) ? 32'd0 : 32'd1);
            chk("fair_wen", {31'd0, W_en}, 32'd1);
            chk("fair_waddr", {27'd0, W_Addr}, (k % 2 == 0) ? 32'd4 : 32'd6);
        end

        // Reset mid-operation with ALU and LOAD slots full
        req_valid = 3'b000;
        #1;
        chk("mid_busy_pre", {31'd0, busy}, 32'd1);
        set_req(2, 1'b1, 5'd9, 32'hC0);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        req_valid = 3'b000;
        #1;
        chk("mid_busy",  {31'd0, busy}, 32'd0);
        chk("mid_ready", {29'd0, req_ready}, 32'd7);
        chk("mid_gid",   {30'd0, grant_id}, 32'd3);
        chk("mid_wen",   {31'd0, W_en}, 32'd0);
        tick();
        chk("mid_wen_after", {31'd0, W_en}, 32'd0);
        chk("mid_gid_after", {30'd0, grant_id}, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_wport_arbiter.md
RF_WPORT_ARBITER -- requirements
Module: rf_wport_arbiter

Interface
REQ-001 Parameter NUM_REQ, 3, number of write requesters (0=ALU, 1=LOAD, 2=MULDIV); the design SHALL support only 3.
REQ-002 Parameter D_WIDTH / RA_WIDTH, 32 / 5, data and register-address widths taken from the shared defines.
REQ-003 Clk  input  1  clock; all state SHALL update on rising edge.
REQ-004 Rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  3  per-requester write request.
REQ-006 req_ready  output  3  per-requester accept; transfer occurs when valid and ready are both high at a rising edge.
REQ-007 req_addr  input  3x5  per-requester destination register.
REQ-008 req_data  input  3x32  per-requester write data.
REQ-009 W_en  output  1  register-file write enable, registered.
REQ-010 W_Addr  output  5  register-file write address, registered.
REQ-011 W_Data  output  32  register-file write data, registered.
REQ-012 grant_id  output  2  index of the requester driving the current W_* (3 = none).
REQ-013 busy  output  1  high while any holding slot is full.

Function
REQ-014 Each requester SHALL own a 1-entry holding slot (full flag, addr, data) loaded on a completed transfer.
REQ-015 req_ready[i] SHALL equal (not full[i]) OR (slot i granted this cycle), so a granted slot can be refilled on the same edge it is drained.
REQ-016 Each cycle a round-robin arbiter SHALL grant one full slot, searching from (last_grant+1) mod 3; last_grant SHALL update only when a grant occurs.
REQ-017 On the edge following a grant, W_en SHALL be 1, W_Addr/W_Data SHALL hold the granted slot contents, grant_id SHALL hold the slot index, and the slot SHALL be freed unless refilled on that edge.
REQ-018 With no full slot, W_en SHALL be 0 on the next cycle, grant_id SHALL be 3, and W_Addr/W_Data SHALL hold their previous values.
REQ-019 Latency: a request accepted at edge N into an otherwise empty arbiter SHALL appear on W_* during the cycle after edge N+1.
REQ-020 A request with addr 0 SHALL be accepted, consume a grant, and be dropped: W_en stays 0, grant_id shows the index.
REQ-021 Starvation bound: a full slot SHALL be granted within 3 cycles of becoming full.
REQ-022 Same-address requests in different slots SHALL be written in grant order; the arbiter performs no merging or reordering by address.
REQ-023 Sustained throughput SHALL be one write per cycle whenever at least one slot is full.
REQ-024 busy SHALL be the OR of the three full flags, combinational from state.

Reset
REQ-025 While Rst is high at an edge: all full flags 0, last_grant 2 (so slot 0 wins first), W_en 0, W_Addr 0, W_Data 0, grant_id 3.
REQ-026 Transfers presented during a reset cycle SHALL be discarded; pending slot contents SHALL be lost; req_ready SHALL be 3'b111 in the first cycle after reset.

Structure
REQ-027 D_WIDTH, RA_WIDTH, NUM_REQ and the "no grant" code 3 SHALL live in the shared define header.
REQ-028 Round-robin selection SHALL be a sub-module rr_arbiter3 (inputs: request mask, last_grant; outputs: one-hot grant, grant index, any_grant), purely combinational.

Verification
REQ-029 Single: ALU writes r5=0x1234 at edge N -> W_en=1, W_Addr=5, W_Data=0x1234, grant_id=0 during cycle after N+1; W_en=0 next.
REQ-030 Contention: all three valid in one cycle (r1,r2,r3) after reset -> writes r1, r2, r3 on three consecutive cycles, grant_id 0,1,2.
REQ-031 Back-to-back: LOAD holds valid for 4 transfers, others idle -> req_ready[1] stays 1, four consecutive W_en cycles.
REQ-032 Zero register: MULDIV writes r0=0xFFFF -> grant_id=2, W_en=0, slot freed, busy falls.
REQ-033 Fairness: ALU and LOAD continuously valid -> grants alternate 0,1,0,1; no slot waits more than 3 cycles.
REQ-034 Reset mid-operation: Rst with two slots full -> no W_en after reset, busy=0, req_ready=3'b111, grant_id=3.
